// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: command sequencer for kernel load, image load, conv run and result streaming over UART.
// Optional inter-byte timeout in the load states: define CONV_SEQ_TIMEOUT_EN.
module conv_seq_ctrl #(
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  output logic [71:0]       kernel,
  output logic              kernel_valid,
  output logic              img_we,
  output logic [ADDR_W-1:0] img_addr,
  output logic [7:0]        img_wdata,
  output logic              conv_start,
  input  logic              conv_done,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [7:0]        res_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_IMG, RUN, SEND_RD, SEND_WT, SEND_PL, SEND_GP} state_t;
  localparam logic [ADDR_W:0]   NPIX     = (ADDR_W+1)'(IMG_W*IMG_H);
  localparam logic [ADDR_W-1:0] LAST_RES = ADDR_W'((IMG_W-2)*(IMG_H-2)-1);
  if (2**ADDR_W < IMG_W*IMG_H || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("conv_seq_ctrl: invalid parameter set");
  end
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W:0]     pix_q, pix_d;
  logic [71:0]         kernel_q, kernel_d;
  logic                kernel_valid_q, kernel_valid_d;
  logic                img_we_q, img_we_d;
  logic [ADDR_W-1:0]   img_addr_q, img_addr_d;
  logic [7:0]          img_wdata_q, img_wdata_d;
  logic                conv_start_q, conv_start_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                err_q, err_d;
`ifdef CONV_SEQ_TIMEOUT_EN
  logic [31:0]         tmo_q, tmo_d;
  logic                in_load;
`endif
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pix_d          = pix_q;
    kernel_d       = kernel_q;
    kernel_valid_d = kernel_valid_q;
    img_we_d       = 1'b0;
    img_addr_d     = img_addr_q;
    img_wdata_d    = img_wdata_q;
    conv_start_d   = 1'b0;
    res_addr_d     = res_addr_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    err_d          = err_q;
    case (state_q)
      IDLE: if (rx_vld) begin
        if (rx_data == 8'hA1) begin
          state_d        = LOAD_K;
          kernel_valid_d = 1'b0;
          cnt_d          = 4'd0;
          err_d          = 1'b0;
        end else if (rx_data == 8'hA2) begin
          state_d = LOAD_IMG;
          pix_d   = '0;
          err_d   = 1'b0;
        end else if (rx_data == 8'hA3 && kernel_valid_q) begin
          state_d      = RUN;
          conv_start_d = 1'b1;
          err_d        = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      LOAD_K: if (rx_vld) begin
        kernel_d[{cnt_q, 3'b000} +: 8] = rx_data;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          kernel_valid_d = 1'b1;
          state_d        = IDLE;
        end
      end
      // leave only after the last pixel's write strobe so img_we stays inside LOAD_IMG
      LOAD_IMG: if (pix_q == NPIX) begin
        state_d = IDLE;
      end else if (rx_vld) begin
        img_we_d    = 1'b1;
        img_wdata_d = rx_data;
        img_addr_d  = pix_q[ADDR_W-1:0];
        pix_d       = pix_q + (ADDR_W+1)'(1);
      end
      RUN: if (conv_done) begin
        state_d    = SEND_RD;
        res_addr_d = '0;
      end
      SEND_RD: state_d = SEND_WT;
      SEND_WT: begin
        tx_data_d = res_rdata;
        state_d   = SEND_PL;
      end
      SEND_PL: if (!tx_busy) begin
        tx_start_d = 1'b1;
        state_d    = SEND_GP;
      end
      SEND_GP: if (res_addr_q == LAST_RES) begin
        state_d = IDLE;
      end else begin
        res_addr_d = res_addr_q + ADDR_W'(1);
        state_d    = SEND_RD;
      end
      default: state_d = IDLE;
    endcase
`ifdef CONV_SEQ_TIMEOUT_EN
    in_load = state_q == LOAD_K || state_q == LOAD_IMG;
    tmo_d   = (in_load && !rx_vld) ? tmo_q + 32'd1 : 32'd0;
    if (in_load && state_d == state_q && !rx_vld && tmo_q + 32'd1 == 32'(TIMEOUT_CYC)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tmo_d   = 32'd0;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pix_q          <= '0;
      kernel_q       <= '0;
      kernel_valid_q <= 1'b0;
      img_we_q       <= 1'b0;
      img_addr_q     <= '0;
      img_wdata_q    <= '0;
      conv_start_q   <= 1'b0;
      res_addr_q     <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pix_q          <= pix_d;
      kernel_q       <= kernel_d;
      kernel_valid_q <= kernel_valid_d;
      img_we_q       <= img_we_d;
      img_addr_q     <= img_addr_d;
      img_wdata_q    <= img_wdata_d;
      conv_start_q   <= conv_start_d;
      res_addr_q     <= res_addr_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      err_q          <= err_d;
    end
  end
`ifdef CONV_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) tmo_q <= !rst ? 32'd0 : tmo_d;
`endif
  assign kernel       = kernel_q;
  assign kernel_valid = kernel_valid_q;
  assign img_we       = img_we_q;
  assign img_addr     = img_addr_q;
  assign img_wdata    = img_wdata_q;
  assign conv_start   = conv_start_q;
  assign res_addr     = res_addr_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign err          = err_q;
  assign busy         = state_q != IDLE;
endmodule
